// File: rtl/coreriscv_axi4_probe_egress_queue.sv
// Decoupling FIFO between the probe arbiter and the probe network output port.
// Optional flow-through bypass when empty: define CORERISCV_AXI4_PROBE_QUEUE_FLOW_EN.
module coreriscv_axi4_probe_egress_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              io_enq_ready,
  input  logic              io_enq_valid,
  input  logic [1:0]        io_enq_bits_header_src,
  input  logic [1:0]        io_enq_bits_header_dst,
  input  logic [ADDR_W-1:0] io_enq_bits_payload_addr_block,
  input  logic [1:0]        io_enq_bits_payload_p_type,
  input  logic [1:0]        io_enq_chosen,
  input  logic              io_deq_ready,
  output logic              io_deq_valid,
  output logic [1:0]        io_deq_bits_header_src,
  output logic [1:0]        io_deq_bits_header_dst,
  output logic [ADDR_W-1:0] io_deq_bits_payload_addr_block,
  output logic [1:0]        io_deq_bits_payload_p_type,
  output logic [1:0]        io_deq_chosen,
  output logic [CNT_W-1:0]  io_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = 8 + ADDR_W;

  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;
  logic [ENT_W-1:0] storage [DEPTH];

  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             flow;
  logic             do_enq;
  logic             do_deq;
  logic             wr_en;
  logic             rd_en;
  logic [ENT_W-1:0] enq_word;
  logic [ENT_W-1:0] head_word;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

`ifdef CORERISCV_AXI4_PROBE_QUEUE_FLOW_EN
  assign flow = empty & io_enq_valid;
`else
  assign flow = 1'b0;
`endif

  assign enq_word = {io_enq_bits_header_src, io_enq_bits_header_dst,
                     io_enq_bits_payload_addr_block, io_enq_bits_payload_p_type,
                     io_enq_chosen};

  assign io_enq_ready = ~full;
  assign io_deq_valid = ~empty | flow;
  assign head_word    = flow ? enq_word : storage[deq_ptr];

  assign {io_deq_bits_header_src, io_deq_bits_header_dst,
          io_deq_bits_payload_addr_block, io_deq_bits_payload_p_type,
          io_deq_chosen} = head_word;

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;

  // A bypassed entry (flow with ready network) touches neither storage nor pointers.
  assign wr_en = do_enq & ~(flow & io_deq_ready);
  assign rd_en = do_deq & ~flow;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and full-flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (wr_en) enq_ptr <= ptr_next(enq_ptr);
      if (rd_en) deq_ptr <= ptr_next(deq_ptr);
      if (wr_en != rd_en) maybe_full <= wr_en;
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) storage[enq_ptr] <= enq_word;
  end

  // Occupancy from pointer distance; equal pointers disambiguated by maybe_full.
  always_comb begin
    io_count = '0;
    if (enq_ptr > deq_ptr)
      io_count = CNT_W'(enq_ptr) - CNT_W'(deq_ptr);
    else if (enq_ptr < deq_ptr)
      io_count = CNT_W'(DEPTH) + CNT_W'(enq_ptr) - CNT_W'(deq_ptr);
    else if (maybe_full)
      io_count = CNT_W'(DEPTH);
  end

endmodule

// File: tb/tb_coreriscv_axi4_probe_egress_queue.sv
// Self-checking bench for coreriscv_axi4_probe_egress_queue (queue model + directed vectors).
module tb_coreriscv_axi4_probe_egress_queue;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned CNT_W  = 5;
`ifdef CORERISCV_AXI4_PROBE_QUEUE_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]        src;
    logic [1:0]        dst;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        pt;
    logic [1:0]        ch;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_enq_ready;
  logic              io_enq_valid;
  logic [1:0]        io_enq_bits_header_src;
  logic [1:0]        io_enq_bits_header_dst;
  logic [ADDR_W-1:0] io_enq_bits_payload_addr_block;
  logic [1:0]        io_enq_bits_payload_p_type;
  logic [1:0]        io_enq_chosen;
  logic              io_deq_ready;
  logic              io_deq_valid;
  logic [1:0]        io_deq_bits_header_src;
  logic [1:0]        io_deq_bits_header_dst;
  logic [ADDR_W-1:0] io_deq_bits_payload_addr_block;
  logic [1:0]        io_deq_bits_payload_p_type;
  logic [1:0]        io_deq_chosen;
  logic [CNT_W-1:0]  io_count;

  int checks = 0;
  int errors = 0;
  ent_t q[$];
  bit   live = 1'b0;

  coreriscv_axi4_probe_egress_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .io_enq_ready                   (io_enq_ready),
    .io_enq_valid                   (io_enq_valid),
    .io_enq_bits_header_src         (io_enq_bits_header_src),
    .io_enq_bits_header_dst         (io_enq_bits_header_dst),
    .io_enq_bits_payload_addr_block (io_enq_bits_payload_addr_block),
    .io_enq_bits_payload_p_type     (io_enq_bits_payload_p_type),
    .io_enq_chosen                  (io_enq_chosen),
    .io_deq_ready                   (io_deq_ready),
    .io_deq_valid                   (io_deq_valid),
    .io_deq_bits_header_src         (io_deq_bits_header_src),
    .io_deq_bits_header_dst         (io_deq_bits_header_dst),
    .io_deq_bits_payload_addr_block (io_deq_bits_payload_addr_block),
    .io_deq_bits_payload_p_type     (io_deq_bits_payload_p_type),
    .io_deq_chosen                  (io_deq_chosen),
    .io_count                       (io_count)
  );

  always #5 clk = ~clk;

  function automatic ent_t enq_ent();
    return '{src: io_enq_bits_header_src, dst: io_enq_bits_header_dst,
             addr: io_enq_bits_payload_addr_block, pt: io_enq_bits_payload_p_type,
             ch: io_enq_chosen};
  endfunction

  function automatic ent_t deq_ent();
    return '{src: io_deq_bits_header_src, dst: io_deq_bits_header_dst,
             addr: io_deq_bits_payload_addr_block, pt: io_deq_bits_payload_p_type,
             ch: io_deq_chosen};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most DEPTH entries, optional same-cycle bypass when empty.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      live = 1'b1;
    end else if (live) begin
      bit bypass;
      bit pop;
      bit push;
      bypass = FLOW && q.size() == 0 && io_enq_valid && io_deq_ready;
      pop    = q.size() > 0 && io_deq_ready;
      push   = io_enq_valid && q.size() < DEPTH && !bypass;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(enq_ent());
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (live) begin
      bit   exp_valid;
      ent_t exp_head;
      exp_valid = q.size() > 0 || (FLOW && io_enq_valid);
      exp_head  = (q.size() > 0) ? q[0] : enq_ent();
      chk("model_enq_ready", 64'(io_enq_ready), 64'(q.size() < DEPTH));
      chk("model_deq_valid", 64'(io_deq_valid), 64'(exp_valid));
      chk("model_count", 64'(io_count), 64'(q.size()));
      if (exp_valid && io_deq_valid) chk("model_head", 64'(deq_ent()), 64'(exp_head));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [1:0] d,
                       input logic [ADDR_W-1:0] a, input logic [1:0] p,
                       input logic [1:0] c, input bit dr);
    io_enq_valid                   = v;
    io_enq_bits_header_src         = s;
    io_enq_bits_header_dst         = d;
    io_enq_bits_payload_addr_block = a;
    io_enq_bits_payload_p_type     = p;
    io_enq_chosen                  = c;
    io_deq_ready                   = dr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 2'd3, 2'd3, 26'h3FFFFFF, 2'd1, 2'd1, 1'b0);
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 2'd0, 2'd0, '0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("rst_deq_valid", 64'(io_deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(io_enq_ready), 64'd1);
    chk("rst_count", 64'(io_count), 64'd0);
    step();
    @(negedge clk);
    chk("rst_nothing_captured", 64'(io_count), 64'd0);

    // Fill to full with the network stalled.
    step(); drive(1'b1, 2'd1, 2'd2, 26'h0ABCDEF, 2'd2, 2'd3, 1'b0);
    @(negedge clk);
    chk("fill_count0", 64'(io_count), 64'd0);
    step(); drive(1'b1, 2'd1, 2'd2, 26'h1000001, 2'd2, 2'd0, 1'b0);
    @(negedge clk);
    chk("fill_count1", 64'(io_count), 64'd1);
    chk("fill_head_addr1", 64'(io_deq_bits_payload_addr_block), 64'h0ABCDEF);
    step(); drive(1'b1, 2'd0, 2'd1, 26'h3333333, 2'd1, 2'd2, 1'b0);
    @(negedge clk);
    chk("fill_count2", 64'(io_count), 64'd2);
    chk("fill_enq_ready", 64'(io_enq_ready), 64'd0);
    chk("fill_head_addr2", 64'(io_deq_bits_payload_addr_block), 64'h0ABCDEF);
    chk("fill_head_chosen", 64'(io_deq_chosen), 64'd3);
    step();
    @(negedge clk);
    chk("held_off_count", 64'(io_count), 64'd2);

    // Drain in order.
    step(); drive(1'b0, 2'd0, 2'd0, '0, 2'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("drain_head0", 64'(io_deq_bits_payload_addr_block), 64'h0ABCDEF);
    step();
    @(negedge clk);
    chk("drain_head1", 64'(io_deq_bits_payload_addr_block), 64'h1000001);
    chk("drain_head1_chosen", 64'(io_deq_chosen), 64'd0);
    chk("drain_count1", 64'(io_count), 64'd1);
    step();
    @(negedge clk);
    chk("drain_count0", 64'(io_count), 64'd0);
    chk("drain_valid0", 64'(io_deq_valid), 64'd0);

    // Simultaneous enq/deq at occupancy 1, wrapping pointers.
    step(); drive(1'b1, 2'd2, 2'd1, 26'h0000FFF, 2'd3, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(); drive(1'b1, 2'(i), 2'(i + 1), ADDR_W'(i), 2'(i + 2), 2'(i + 3), 1'b1);
      @(negedge clk);
      chk("sim_count", 64'(io_count), 64'd1);
      chk("sim_head", 64'(io_deq_bits_payload_addr_block),
          (i == 0) ? 64'h0000FFF : 64'(i - 1));
    end
    step(); drive(1'b0, 2'd0, 2'd0, '0, 2'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("sim_last_head", 64'(io_deq_bits_payload_addr_block), 64'd7);
    step(); drive(1'b0, 2'd0, 2'd0, '0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("sim_empty", 64'(io_count), 64'd0);

    // Reset with two entries queued and an enq pending.
    step(); drive(1'b1, 2'd1, 2'd1, 26'h0111111, 2'd1, 2'd1, 1'b0);
    step(); drive(1'b1, 2'd2, 2'd2, 26'h0222222, 2'd2, 2'd2, 1'b0);
    step(); drive(1'b1, 2'd3, 2'd3, 26'h0333333, 2'd3, 2'd3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pre_count", 64'(io_count), 64'd2);
    step(); reset = 1'b0; drive(1'b0, 2'd0, 2'd0, '0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("midrst_count", 64'(io_count), 64'd0);
    chk("midrst_valid", 64'(io_deq_valid), 64'd0);
    chk("midrst_ready", 64'(io_enq_ready), 64'd1);

    // Empty-queue latency (bypass when flow-through is built in).
    step(); drive(1'b1, 2'd1, 2'd0, 26'h2222222, 2'd0, 2'd2, 1'b1);
    @(negedge clk);
    chk("flow_valid_now", 64'(io_deq_valid), 64'(FLOW));
    if (FLOW) chk("flow_addr_now", 64'(io_deq_bits_payload_addr_block), 64'h2222222);
    chk("flow_count_now", 64'(io_count), 64'd0);
    step(); drive(1'b0, 2'd0, 2'd0, '0, 2'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("flow_valid_next", 64'(io_deq_valid), 64'(!FLOW));
    if (!FLOW) chk("flow_addr_next", 64'(io_deq_bits_payload_addr_block), 64'h2222222);
    step();
    @(negedge clk);
    chk("flow_final_count", 64'(io_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
